rx_mass_check: RTL

RX_MASS_CHECK -- requirements
Module: rx_mass_check

---
 rtl/rx_mass_check_if.sv | 22 ++
 rtl/rx_mass_check.sv | 77 +++++++
 2 files changed

// File: rtl/rx_mass_check_if.sv
// rx_mass_check_if: 32-bit rx stream in, 8-bit report stream out, plus status (master = source/sink side, slave = checker side)
interface rx_mass_check_if;
  logic        i_tready;
  logic        i_tvalid;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tlast;
  logic        o_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        o_pkt_done;
  logic        o_err_flag;
  modport master (
    input  i_tready, o_tvalid, o_tdata, o_tlast, o_pkt_done, o_err_flag,
    output i_tvalid, i_tdata, i_tkeep, i_tlast, o_tready
  );
  modport slave (
    output i_tready, o_tvalid, o_tdata, o_tlast, o_pkt_done, o_err_flag,
    input  i_tvalid, i_tdata, i_tkeep, i_tlast, o_tready
  );
endinterface

// File: rtl/rx_mass_check.sv
// rx_mass_check: checks rx bytes against a 0,1,2.. pattern and reports byte/error counts; ports clk, rst, s_bus (i_* rx stream, o_* report stream, o_pkt_done, o_err_flag)
module rx_mass_check #(
  parameter logic [15:0] REPORT_MAGIC = 16'h5AA5,
  parameter int          ERR_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  rx_mass_check_if.slave s_bus
);
  typedef enum logic {RECV, REPORT} state_t;
  state_t           r_state, w_state_nxt;
  logic [31:0]      r_byte_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [2:0]       r_idx;
  logic             r_pkt_done;
  logic             r_err_flag;
  logic [7:0]       w_pos;
  logic [2:0]       w_add;
  logic [2:0]       w_mis;
  logic [ERR_W:0]   w_err_sum;
  logic [ERR_W-1:0] w_err_nxt;
  logic [63:0]      w_rpt;
  logic             w_acc;
  logic             w_ohs;
  assign w_acc = s_bus.i_tvalid && r_state == RECV;
  assign w_ohs = s_bus.o_tready && r_state == REPORT;
  always_comb begin
    w_pos = r_byte_cnt[7:0];
    w_add = '0;
    w_mis = '0;
    for (int k = 0; k < 4; k++) begin
      if (s_bus.i_tkeep[k]) begin
        w_mis = w_mis + 3'(s_bus.i_tdata[8*k +: 8] != w_pos);
        w_pos = w_pos + 8'd1;
        w_add = w_add + 3'd1;
      end
    end
  end
  assign w_err_sum = {1'b0, r_err_cnt} + (ERR_W+1)'(w_mis);
  assign w_err_nxt = w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
  assign w_rpt     = {REPORT_MAGIC, r_err_cnt, r_byte_cnt};
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == RECV) ? ((w_acc && s_bus.i_tlast) ? REPORT : RECV)
                                    : ((w_ohs && r_idx == 3'd7) ? RECV : REPORT);
  end
  always_ff @(posedge clk) r_state <= rst ? RECV : w_state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_err_cnt  <= '0;
      r_idx      <= '0;
      r_pkt_done <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      r_pkt_done <= w_acc && s_bus.i_tlast;
      if (w_acc) begin
        r_byte_cnt <= r_byte_cnt + 32'(w_add);
        r_err_cnt  <= w_err_nxt;
        r_err_flag <= r_err_flag | (s_bus.i_tlast && w_err_nxt != '0);
      end
      if (w_ohs) begin
        r_idx <= r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          r_byte_cnt <= '0;
          r_err_cnt  <= '0;
        end
      end
    end
  end
  assign s_bus.i_tready   = r_state == RECV;
  assign s_bus.o_tvalid   = r_state == REPORT;
  assign s_bus.o_tdata    = (r_state == REPORT) ? w_rpt[{r_idx, 3'b000} +: 8] : 8'd0;
  assign s_bus.o_tlast    = r_state == REPORT && r_idx == 3'd7;
  assign s_bus.o_pkt_done = r_pkt_done;
  assign s_bus.o_err_flag = r_err_flag;
endmodule
